// File: rtl/uart_baud_ctrl.sv
// Baud timing controller: 16x oversample and bit-rate ticks with idle-gated divisor updates.
// Optional AUTOBAUD_EN adds start-bit width measurement to derive the divisor.
module uart_baud_ctrl #(
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(54),
  parameter int unsigned      OS_RATE     = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [DIV_W-1:0] cfg_div_in,
  input  logic             cfg_req_in,
  output logic             cfg_ack_out,
  output logic             cfg_err_out,
  input  logic             uart_busy_in,
  output logic [DIV_W-1:0] div_out,
  output logic             os_tick_out,
  output logic             baud_tick_out,
  output logic             busy_out
`ifdef AUTOBAUD_EN
  ,
  input  logic             rx_in,
  input  logic             ab_start_in,
  output logic             ab_done_out
`endif
);

  // state   | meaning
  // IDLE    | ticks free-running, accepting requests
  // PEND    | divisor latched, waiting for the UART to go idle
  // APPLY   | load divisor and re-phase counters, ticks suppressed
  // RESP    | one-cycle ack (with err) back to the host
  // AB_WAIT | autobaud: waiting for the start-bit falling edge
  // AB_MEAS | autobaud: counting clocks while rx is low

  localparam int unsigned      BD_W    = $clog2(OS_RATE);
  localparam logic [BD_W-1:0]  BD_MAX  = BD_W'(OS_RATE - 1);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PEND    = 3'd1,
    APPLY   = 3'd2,
    RESP    = 3'd3
`ifdef AUTOBAUD_EN
    ,
    AB_WAIT = 3'd4,
    AB_MEAS = 3'd5
`endif
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] nxt_div;
  logic [DIV_W-1:0] os_cnt;
  logic [BD_W-1:0]  bd_cnt;
  logic             apply_next;

  // The tick that would land in the APPLY cycle is dropped at its source.
  assign apply_next = (state == PEND) && !uart_busy_in;

`ifdef AUTOBAUD_EN
  localparam int unsigned AB_W = DIV_W + 4;

  logic            rx_s1, rx_s2, rx_d;
  logic            ab_mode;
  logic [AB_W-1:0] ab_cnt;
  logic [AB_W-1:0] ab_q;
  logic            ab_full;

  assign ab_q    = ab_cnt >> BD_W;
  assign ab_full = &ab_cnt;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      nxt_div       <= DEFAULT_DIV;
      div_out       <= DEFAULT_DIV;
      os_cnt        <= '0;
      bd_cnt        <= '0;
      os_tick_out   <= 1'b0;
      baud_tick_out <= 1'b0;
      cfg_ack_out   <= 1'b0;
      cfg_err_out   <= 1'b0;
      busy_out      <= 1'b0;
`ifdef AUTOBAUD_EN
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_d          <= 1'b1;
      ab_mode       <= 1'b0;
      ab_cnt        <= '0;
      ab_done_out   <= 1'b0;
`endif
    end else begin
      cfg_ack_out <= 1'b0;
      cfg_err_out <= 1'b0;
`ifdef AUTOBAUD_EN
      ab_done_out <= 1'b0;
      rx_s1       <= rx_in;
      rx_s2       <= rx_s1;
      rx_d        <= rx_s2;
`endif

      if (state == APPLY) begin
        os_cnt        <= '0;
        bd_cnt        <= '0;
        os_tick_out   <= 1'b0;
        baud_tick_out <= 1'b0;
      end else if (os_cnt == div_out - 1'b1) begin
        os_cnt        <= '0;
        bd_cnt        <= bd_cnt + 1'b1;
        os_tick_out   <= !apply_next;
        baud_tick_out <= !apply_next && (bd_cnt == BD_MAX);
      end else begin
        os_cnt        <= os_cnt + 1'b1;
        os_tick_out   <= 1'b0;
        baud_tick_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_req_in) begin
            nxt_div  <= cfg_div_in;
            busy_out <= 1'b1;
            if (cfg_div_in < MIN_DIV) begin
              state       <= RESP;
              cfg_ack_out <= 1'b1;
              cfg_err_out <= 1'b1;
            end else begin
              state <= PEND;
            end
          end
`ifdef AUTOBAUD_EN
          else if (ab_start_in) begin
            state    <= AB_WAIT;
            ab_mode  <= 1'b1;
            busy_out <= 1'b1;
          end
`endif
        end
        PEND: begin
          if (!uart_busy_in) state <= APPLY;
        end
        APPLY: begin
          div_out     <= nxt_div;
          state       <= RESP;
          cfg_ack_out <= 1'b1;
          cfg_err_out <= 1'b0;
`ifdef AUTOBAUD_EN
          ab_done_out <= ab_mode;
`endif
        end
        RESP: begin
          state    <= IDLE;
          busy_out <= 1'b0;
`ifdef AUTOBAUD_EN
          ab_mode  <= 1'b0;
`endif
        end
`ifdef AUTOBAUD_EN
        AB_WAIT: begin
          if (rx_d && !rx_s2) begin
            ab_cnt <= AB_W'(1);
            state  <= AB_MEAS;
          end
        end
        AB_MEAS: begin
          if (rx_s2) begin
            // Quotient must fit the divisor register and meet the minimum.
            if ((ab_q < AB_W'(2)) || ((ab_q >> DIV_W) != '0)) begin
              state       <= RESP;
              cfg_ack_out <= 1'b1;
              cfg_err_out <= 1'b1;
              ab_done_out <= 1'b1;
            end else begin
              nxt_div <= ab_q[DIV_W-1:0];
              state   <= PEND;
            end
          end else if (ab_full) begin
            state       <= RESP;
            cfg_ack_out <= 1'b1;
            cfg_err_out <= 1'b1;
            ab_done_out <= 1'b1;
          end else begin
            ab_cnt <= ab_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
